// File: rtl/apb_arbiter.sv
// apb_arbiter: round-robin arbiter that funnels NREQ requesters onto one APB completer.
//
// Optional feature: define APB_TIMEOUT_EN to bound ACCESS wait states to TIMEOUT_CYCLES.
// A timed-out transfer completes with rsp_err=1 and rsp_rdata=0.
//
// Ports
//   PCLK, PRESET          clock (rising edge), synchronous active-high reset
//   req_valid/req_write   per-requester request and direction (1 = write)
//   req_addr/req_wdata    per-requester address / write data, slice i = [32i+31:32i]
//   req_grant             one-hot current owner, zero in IDLE
//   req_done              one-cycle completion pulse to the owner
//   rsp_rdata/rsp_err     response, valid while req_done is high
//   PSEL..PWDATA          APB requester-side outputs (all registered)
//   PRDATA/PREADY/PSLVERR APB completer response
module apb_arbiter #(
    parameter int unsigned NREQ           = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic               PCLK,
    input  logic               PRESET,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_write,
    input  logic [NREQ*32-1:0] req_addr,
    input  logic [NREQ*32-1:0] req_wdata,
    output logic [NREQ-1:0]    req_grant,
    output logic [NREQ-1:0]    req_done,
    output logic [31:0]        rsp_rdata,
    output logic               rsp_err,
    output logic               PSEL,
    output logic               PENABLE,
    output logic               PWRITE,
    output logic [31:0]        PADDR,
    output logic [31:0]        PWDATA,
    input  logic [31:0]        PRDATA,
    input  logic               PREADY,
    input  logic               PSLVERR
);

    localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Configuration sanity checks, evaluated at elaboration.
    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("apb_arbiter: NREQ must be in 2..8");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("apb_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   last_q, last_d;
    logic [IdxW-1:0]   owner_q, owner_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [31:0]       paddr_q, paddr_d;
    logic [31:0]       pwdata_q, pwdata_d;

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0]   tcnt_q, tcnt_d;
`endif

    // A requester being acknowledged this cycle must not win again immediately.
    logic [NREQ-1:0]   eligible;
    logic              pick_valid;
    logic [IdxW-1:0]   pick_idx;

    assign eligible = req_valid & ~done_q;

    // Round-robin search starting one past the last-served index.
    always_comb begin
        int unsigned cand;
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = (32'(last_q) + k) % NREQ;
            if (!pick_valid && eligible[IdxW'(cand)]) begin
                pick_valid = 1'b1;
                pick_idx   = IdxW'(cand);
            end
        end
    end

    always_comb begin
        logic        finish;
        logic        fin_err;
        logic [31:0] fin_rdata;
        state_d   = state_q;
        last_d    = last_q;
        owner_d   = owner_q;
        grant_d   = grant_q;
        done_d    = '0;
        rdata_d   = rdata_q;
        err_d     = err_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        finish    = 1'b0;
        fin_err   = 1'b0;
        fin_rdata = '0;
`ifdef APB_TIMEOUT_EN
        tcnt_d    = tcnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    owner_d   = pick_idx;
                    grant_d   = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
                    paddr_d   = req_addr[{pick_idx, 5'b0} +: 32];
                    pwdata_d  = req_wdata[{pick_idx, 5'b0} +: 32];
                    pwrite_d  = req_write[pick_idx];
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = StSetup;
`ifdef APB_TIMEOUT_EN
                    tcnt_d    = '0;
`endif
                end
            end
            StSetup: begin
                penable_d = 1'b1;
                state_d   = StAccess;
            end
            StAccess: begin
                if (PREADY) begin
                    finish    = 1'b1;
                    fin_err   = PSLVERR;
                    fin_rdata = pwrite_q ? 32'h0 : PRDATA;
`ifdef APB_TIMEOUT_EN
                end else if (tcnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                    // This edge closes the TIMEOUT_CYCLES-th wait cycle.
                    finish    = 1'b1;
                    fin_err   = 1'b1;
                    fin_rdata = '0;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
`endif
                end
            end
            default: state_d = StIdle;
        endcase

        if (finish) begin
            done_d    = grant_q;
            rdata_d   = fin_rdata;
            err_d     = fin_err;
            psel_d    = 1'b0;
            penable_d = 1'b0;
            grant_d   = '0;
            last_d    = owner_q;
            state_d   = StIdle;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= StIdle;
            last_q    <= IdxW'(NREQ - 1);
            owner_q   <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
`ifdef APB_TIMEOUT_EN
            tcnt_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
`ifdef APB_TIMEOUT_EN
            tcnt_q    <= tcnt_d;
`endif
        end
    end

    assign req_grant = grant_q;
    assign req_done  = done_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;

endmodule

// File: doc/apb_arbiter.md
APB_ARBITER -- requirements
Module: apb_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters; legal range 2..8.
REQ-002 Parameter TIMEOUT_CYCLES, default 16: maximum ACCESS wait cycles; used only when APB_TIMEOUT_EN is defined.
REQ-003 The block SHALL use one clock and a synchronous active-high reset, exposed as ports PCLK and PRESET.
REQ-004 PCLK  in  1  clock; all logic on the rising edge.
REQ-005 PRESET  in  1  synchronous active-high reset.
REQ-006 req_valid  in  NREQ  per-requester request, held high until the matching req_done pulse.
REQ-007 req_write  in  NREQ  per-requester direction: 1 = write, 0 = read.
REQ-008 req_addr  in  NREQ*32  per-requester address; slice i = bits [32i+31:32i].
REQ-009 req_wdata  in  NREQ*32  per-requester write data, same slicing.
REQ-010 req_grant  out  NREQ  one-hot current owner; all zero in IDLE.
REQ-011 req_done  out  NREQ  one-cycle completion pulse to the owner.
REQ-012 rsp_rdata  out  32  read data, valid while req_done is high.
REQ-013 rsp_err  out  1  error flag, valid while req_done is high.
REQ-014 PSEL, PENABLE, PWRITE  out  1 each  APB control signals.
REQ-015 PADDR, PWDATA  out  32 each  APB address and write data.
REQ-016 PRDATA  in  32; PREADY  in  1; PSLVERR  in  1  APB completer response.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, SETUP and ACCESS; all outputs SHALL be registered.
REQ-018 In IDLE with any eligible req_valid bit set, the block SHALL grant one requester, latch its addr/wdata/write into PADDR/PWDATA/PWRITE, set PSEL=1 and PENABLE=0, and go to SETUP on the same edge.
REQ-019 Arbitration SHALL be round-robin: search starts at last-served index +1, modulo NREQ; after reset the last-served index is NREQ-1, so requester 0 has top priority.
REQ-020 A requester whose req_done is high in the current cycle SHALL be ineligible for arbitration in that cycle.
REQ-021 SETUP SHALL last exactly one cycle, then go to ACCESS with PENABLE=1.
REQ-022 In ACCESS with PREADY=0, all APB outputs SHALL hold their values.
REQ-023 In ACCESS with PREADY=1, on the same edge the block SHALL:
- pulse req_done for the owner;
- set rsp_rdata=PRDATA on reads and 0 on writes;
- set rsp_err=PSLVERR;
- drive PSEL=0, PENABLE=0 and clear req_grant;
- update the last-served index and go to IDLE.
REQ-024 Each transfer SHALL cost at least 3 cycles: request to PSEL is 1 edge, PENABLE follows 1 cycle later, and req_done appears on the edge that samples PREADY.
REQ-025 There SHALL be no back-to-back ACCESS; at least one IDLE cycle SHALL separate transfers.
REQ-026 A requester dropping req_valid while granted SHALL NOT abort the transfer; it still completes and still gets req_done.
REQ-027 PADDR, PWDATA and PWRITE SHALL stay stable from SETUP through the end of ACCESS, whatever req_* inputs do.

Reset
REQ-028 While PRESET=1 at a rising edge, the block SHALL enter IDLE and clear all registered outputs to 0 (PSEL, PENABLE, PWRITE, PADDR, PWDATA, req_grant, req_done, rsp_rdata, rsp_err).
REQ-029 Reset SHALL set the last-served index to NREQ-1 and clear the timeout counter.
REQ-030 Reset during SETUP or ACCESS SHALL abandon the transfer with no req_done pulse; PSEL is 0 on the next cycle.

Configuration
REQ-031 With macro APB_TIMEOUT_EN defined, a counter SHALL count ACCESS cycles with PREADY=0.
REQ-032 When that count reaches TIMEOUT_CYCLES, the block SHALL end the transfer as in REQ-023, with rsp_err=1 and rsp_rdata=0.
REQ-033 The timeout counter SHALL clear on every entry to SETUP.
REQ-034 With APB_TIMEOUT_EN undefined, ACCESS SHALL wait indefinitely for PREADY and no counter logic SHALL exist.

Verification
REQ-035 The bench SHALL cover these scenarios:
- Single write, requester 2, addr 0x0000_0010, data 0xDEAD_BEEF, PREADY=1: PSEL seen 1 edge after the request, PENABLE 1 cycle later, req_done[2] lasts 1 cycle, rsp_err=0.
- Read, requester 0, addr 0x04, PRDATA=0x1234_5678, 2 wait states: rsp_rdata=0x1234_5678 while req_done[0]=1; transfer spans 5 cycles.
- Requesters 0..3 held high continuously: grant order 0,1,2,3,0; no requester granted twice in a row.
- PSLVERR=1 on a read from requester 1: rsp_err=1 with req_done[1]; the next transfer has rsp_err=0.
- PRESET pulsed in ACCESS: no req_done; PSEL=0 next cycle; the next grant goes to requester 0.
- With APB_TIMEOUT_EN and TIMEOUT_CYCLES=16, PREADY held 0: req_done comes after 16 wait cycles with rsp_err=1 and rsp_rdata=0.
